// File: rtl/pmips_pkg.sv
// Shared definitions for the PMIPS core: fetch step, default PC width and
// a constant-evaluable log2 helper used to size table indices.
package pmips_pkg;

    localparam int PC_W_DEFAULT = 16;
    localparam int PC_STEP      = 2;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (remaining > 0) begin
                result    = result + 1;
                remaining = remaining >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// W-bit saturating up/down counter with synchronous load. Used both for
// branch direction counters and for the saturating performance counters.
module sat_counter
    import pmips_pkg::*;
#(
    parameter int           W         = 2,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Next value: load wins over counting; counting stops at 0 and all-ones.
    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (en) begin
            if (up && (count_reg != MAX_VAL)) begin
                count_next = count_reg + W'(1);
            end else if (!up && (count_reg != '0)) begin
                count_next = count_reg - W'(1);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= RESET_VAL;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor for PMIPS: direct-mapped BTB with per-entry
// saturating direction counters. Lookup is combinational for IF; the EX
// stage reports resolved branches, which drive mispredict/redirect and
// update the table at the following clock edge.
module branch_predictor
    import pmips_pkg::*;
#(
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 16,
    parameter int MODE    = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [PC_W-1:0] lu_pc,
    output logic            lu_hit,
    output logic            lu_taken,
    output logic [PC_W-1:0] lu_next_pc,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [PC_W-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int IDX_W = clog2(ENTRIES);
    localparam int TAG_W = PC_W - 1 - IDX_W;

    // Freshly allocated entries start weakly taken; reset leaves them weakly not-taken.
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);

    localparam logic [PC_W-1:0] PC_INC = PC_W'(PC_STEP);

    logic [ENTRIES-1:0] valid_reg;
    logic [TAG_W-1:0]   tag_reg    [ENTRIES];
    logic [PC_W-1:0]    target_reg [ENTRIES];
    logic [CTR_W-1:0]   ctr        [ENTRIES];

    // Bit 0 of a halfword-aligned PC carries no information.
    logic unused_pc_lsb;
    assign unused_pc_lsb = lu_pc[0] ^ upd_pc[0];

    // ---------------- Lookup ----------------
    logic [IDX_W-1:0] lu_idx;
    logic [TAG_W-1:0] lu_tag;
    logic [CTR_W-1:0] lu_ctr;

    assign lu_idx = lu_pc[IDX_W:1];
    assign lu_tag = lu_pc[PC_W-1:IDX_W+1];
    assign lu_ctr = ctr[lu_idx];

    // Combinational prediction from pre-update table contents (no bypass).
    always_comb begin
        lu_hit     = valid_reg[lu_idx] && (tag_reg[lu_idx] == lu_tag);
        lu_taken   = (MODE != 0) && lu_hit && lu_ctr[CTR_W-1];
        lu_next_pc = lu_taken ? target_reg[lu_idx] : (lu_pc + PC_INC);
    end

    // ---------------- Resolution ----------------
    logic dir_wrong;
    logic tgt_wrong;

    // Wrong direction, or both taken but to a different target.
    always_comb begin
        dir_wrong   = (upd_taken != upd_pred_taken);
        tgt_wrong   = upd_taken && upd_pred_taken && (upd_target != upd_pred_target);
        mispredict  = upd_valid && (dir_wrong || tgt_wrong);
        redirect_pc = '0;
        if (upd_valid) begin
            redirect_pc = upd_taken ? upd_target : (upd_pc + PC_INC);
        end
    end

    // ---------------- Table update ----------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             table_we;
    logic             alloc;
    logic             train;

    assign upd_idx  = upd_pc[IDX_W:1];
    assign upd_tag  = upd_pc[PC_W-1:IDX_W+1];
    assign upd_hit  = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
    assign table_we = upd_valid && (MODE != 0);
    assign alloc    = table_we && !upd_hit && upd_taken;
    assign train    = table_we && upd_hit;

    // Valid bits: cleared by reset, set when a taken branch allocates.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg <= '0;
        end else if (alloc) begin
            valid_reg[upd_idx] <= 1'b1;
        end
    end

    // Tag/target storage has no reset value, but reset still blocks writes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (alloc) begin
                tag_reg[upd_idx] <= upd_tag;
            end
            if (table_we && upd_taken) begin
                target_reg[upd_idx] <= upd_target;
            end
        end
    end

    // One direction counter per entry; trained on hit, loaded on allocation.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic entry_sel;
            assign entry_sel = (upd_idx == IDX_W'(gi));

            sat_counter #(
                .W         (CTR_W),
                .RESET_VAL (CTR_WEAK_NT)
            ) u_dir_ctr (
                .clock    (clock),
                .reset    (reset),
                .en       (train && entry_sel),
                .up       (upd_taken),
                .load     (alloc && entry_sel),
                .load_val (CTR_WEAK_T),
                .count    (ctr[gi])
            );
        end
    endgenerate

    // ---------------- Performance counters ----------------
    sat_counter #(
        .W         (CNT_W),
        .RESET_VAL ('0)
    ) u_br_count (
        .clock    (clock),
        .reset    (reset),
        .en       (upd_valid),
        .up       (1'b1),
        .load     (1'b0),
        .load_val ('0),
        .count    (br_count)
    );

    sat_counter #(
        .W         (CNT_W),
        .RESET_VAL ('0)
    ) u_miss_count (
        .clock    (clock),
        .reset    (reset),
        .en       (mispredict),
        .up       (1'b1),
        .load     (1'b0),
        .load_val ('0),
        .count    (miss_count)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor. The main instance is checked
// against a bench-side table model through a scoreboard queue; two extra
// instances cover counter saturation (CNT_W=4) and static mode (MODE=0).
module tb_branch_predictor;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- Main instance ----------------
    logic        reset;
    logic [15:0] lu_pc;
    logic        lu_hit, lu_taken;
    logic [15:0] lu_next_pc;
    logic        upd_valid, upd_taken, upd_pred_taken;
    logic [15:0] upd_pc, upd_target, upd_pred_target;
    logic        mispredict;
    logic [15:0] redirect_pc;
    logic [15:0] br_count, miss_count;

    branch_predictor dut (
        .clock(clock), .reset(reset),
        .lu_pc(lu_pc), .lu_hit(lu_hit), .lu_taken(lu_taken), .lu_next_pc(lu_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .br_count(br_count), .miss_count(miss_count)
    );

    // ---------------- Saturation / static-mode instances ----------------
    logic        s_reset;
    logic [15:0] s_lu_pc;
    logic        s_upd_valid, s_upd_taken, s_upd_pred_taken;
    logic [15:0] s_upd_pc, s_upd_target, s_upd_pred_target;

    logic        sa_lu_hit, sa_lu_taken, sa_mispredict;
    logic [15:0] sa_lu_next_pc, sa_redirect_pc;
    logic [3:0]  sa_br_count, sa_miss_count;

    logic        m0_lu_hit, m0_lu_taken, m0_mispredict;
    logic [15:0] m0_lu_next_pc, m0_redirect_pc;
    logic [15:0] m0_br_count, m0_miss_count;

    branch_predictor #(.CNT_W(4), .MODE(1)) dut_sat (
        .clock(clock), .reset(s_reset),
        .lu_pc(s_lu_pc), .lu_hit(sa_lu_hit), .lu_taken(sa_lu_taken), .lu_next_pc(sa_lu_next_pc),
        .upd_valid(s_upd_valid), .upd_pc(s_upd_pc), .upd_taken(s_upd_taken),
        .upd_target(s_upd_target), .upd_pred_taken(s_upd_pred_taken),
        .upd_pred_target(s_upd_pred_target),
        .mispredict(sa_mispredict), .redirect_pc(sa_redirect_pc),
        .br_count(sa_br_count), .miss_count(sa_miss_count)
    );

    branch_predictor #(.CNT_W(16), .MODE(0)) dut_m0 (
        .clock(clock), .reset(s_reset),
        .lu_pc(s_lu_pc), .lu_hit(m0_lu_hit), .lu_taken(m0_lu_taken), .lu_next_pc(m0_lu_next_pc),
        .upd_valid(s_upd_valid), .upd_pc(s_upd_pc), .upd_taken(s_upd_taken),
        .upd_target(s_upd_target), .upd_pred_taken(s_upd_pred_taken),
        .upd_pred_target(s_upd_pred_target),
        .mispredict(m0_mispredict), .redirect_pc(m0_redirect_pc),
        .br_count(m0_br_count), .miss_count(m0_miss_count)
    );

    // ---------------- Checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- Reference model (16 entries, 2-bit counters) ----------------
    typedef struct {
        logic        hit;
        logic        taken;
        logic [15:0] next;
        logic        mp;
        logic [15:0] redir;
        int          br;
        int          miss;
    } exp_t;

    exp_t sb_q[$];

    bit          m_valid [16];
    logic [10:0] m_tag   [16];
    logic [15:0] m_tgt   [16];
    int          m_ctr   [16];
    int          m_br;
    int          m_miss;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_br   = 0;
        m_miss = 0;
    endtask

    // One cycle: drive inputs, push expectation, compare at negedge, advance model.
    task automatic step(input logic [15:0] lpc, input logic uv, input logic [15:0] upc,
                        input logic ut, input logic [15:0] utgt, input logic upt,
                        input logic [15:0] uptgt, input logic rst);
        exp_t e;
        exp_t got;
        int   li;
        int   ui;
        bit   uhit;

        reset           = rst;
        lu_pc           = lpc;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utgt;
        upd_pred_taken  = upt;
        upd_pred_target = uptgt;

        li      = int'(lpc[4:1]);
        e.hit   = m_valid[li] && (m_tag[li] == lpc[15:5]);
        e.taken = e.hit && (m_ctr[li] >= 2);
        e.next  = e.taken ? m_tgt[li] : lpc + 16'd2;
        e.mp    = uv && ((ut != upt) || (ut && upt && (utgt != uptgt)));
        e.redir = !uv ? 16'h0000 : (ut ? utgt : upc + 16'd2);
        e.br    = m_br;
        e.miss  = m_miss;
        sb_q.push_back(e);

        @(negedge clock);
        got = sb_q.pop_front();
        check_value("lu_hit",      32'(lu_hit),      32'(got.hit));
        check_value("lu_taken",    32'(lu_taken),    32'(got.taken));
        check_value("lu_next_pc",  32'(lu_next_pc),  32'(got.next));
        check_value("mispredict",  32'(mispredict),  32'(got.mp));
        check_value("redirect_pc", 32'(redirect_pc), 32'(got.redir));
        check_value("br_count",    32'(br_count),    32'(got.br));
        check_value("miss_count",  32'(miss_count),  32'(got.miss));
        $display("txn rst=%b lu_pc=%h hit=%b taken=%b next=%h | upd=%b pc=%h t=%b tgt=%h -> mp=%b redir=%h br=%0d miss=%0d",
                 rst, lpc, lu_hit, lu_taken, lu_next_pc, uv, upc, ut, utgt,
                 mispredict, redirect_pc, br_count, miss_count);

        // Model state after the coming rising edge.
        if (rst) begin
            model_reset();
        end else if (uv) begin
            ui   = int'(upc[4:1]);
            uhit = m_valid[ui] && (m_tag[ui] == upc[15:5]);
            if (m_br < 65535) m_br++;
            if (got.mp && (m_miss < 65535)) m_miss++;
            if (uhit) begin
                if (ut) begin
                    if (m_ctr[ui] < 3) m_ctr[ui]++;
                    m_tgt[ui] = utgt;
                end else if (m_ctr[ui] > 0) begin
                    m_ctr[ui]--;
                end
            end else if (ut) begin
                m_valid[ui] = 1'b1;
                m_tag[ui]   = upc[15:5];
                m_tgt[ui]   = utgt;
                m_ctr[ui]   = 2;
            end
        end

        @(posedge clock);
        #1;
    endtask

    task automatic lookup(input logic [15:0] lpc);
        step(lpc, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic update(input logic [15:0] lpc, input logic [15:0] upc, input logic ut,
                          input logic [15:0] utgt, input logic upt, input logic [15:0] uptgt);
        step(lpc, 1'b1, upc, ut, utgt, upt, uptgt, 1'b0);
    endtask

    logic [15:0] pool [8] = '{16'h0020, 16'h0040, 16'h0060, 16'h0022,
                              16'h0042, 16'hFFFE, 16'h1234, 16'h0A0C};

    initial begin
        reset = 1'b1; lu_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        s_reset = 1'b1; s_lu_pc = '0; s_upd_valid = 1'b0; s_upd_pc = '0; s_upd_taken = 1'b0;
        s_upd_target = '0; s_upd_pred_taken = 1'b0; s_upd_pred_target = '0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();

        // Defaults after reset.
        lookup(16'h0010);

        // Allocation with a direction mispredict, then hit next cycle.
        update(16'h0020, 16'h0020, 1'b1, 16'h0040, 1'b0, 16'h0000);
        lookup(16'h0020);

        // Hysteresis: saturate up, then two not-taken steps.
        repeat (4) update(16'h0020, 16'h0020, 1'b1, 16'h0040, 1'b1, 16'h0040);
        update(16'h0020, 16'h0020, 1'b0, 16'h0040, 1'b1, 16'h0040);
        lookup(16'h0020);
        update(16'h0020, 16'h0020, 1'b0, 16'h0040, 1'b1, 16'h0040);
        lookup(16'h0020);

        // Aliasing on index 0.
        lookup(16'h0040);
        update(16'h0040, 16'h0040, 1'b1, 16'h0080, 1'b0, 16'h0000);
        lookup(16'h0020);
        lookup(16'h0040);

        // Same cycle lookup and allocation of 0x0060.
        update(16'h0060, 16'h0060, 1'b1, 16'h0100, 1'b0, 16'h0000);
        lookup(16'h0060);

        // Taken with wrong predicted target; target retrained on hit.
        update(16'h0060, 16'h0060, 1'b1, 16'h0120, 1'b1, 16'h0100);
        lookup(16'h0060);

        // PC wrap-around on both sequential paths.
        update(16'hFFFE, 16'hFFFE, 1'b0, 16'h0000, 1'b0, 16'h0000);

        // Reset alongside an update: update discarded, everything cleared.
        step(16'h0070, 1'b1, 16'h0070, 1'b1, 16'h0200, 1'b0, 16'h0000, 1'b1);
        lookup(16'h0070);
        lookup(16'h0060);

        // Randomised traffic over a small PC pool.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] t;
            logic        tk;
            logic        ptk;
            t   = 16'($urandom_range(0, 16'h7FFF)) << 1;
            tk  = 1'($urandom_range(0, 1));
            ptk = 1'($urandom_range(0, 1));
            step(pool[$urandom_range(0, 7)], 1'($urandom_range(0, 3) != 0),
                 pool[$urandom_range(0, 7)], tk, t, ptk,
                 ($urandom_range(0, 1) != 0) ? t : pool[$urandom_range(0, 7)], 1'b0);
        end
        upd_valid = 1'b0;

        // Saturating perf counters (CNT_W=4) and static mode, 20 mispredicting branches.
        s_reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_lu_pc           = 16'h0030;
            s_upd_valid       = 1'b1;
            s_upd_pc          = 16'h0030;
            s_upd_taken       = 1'b1;
            s_upd_target      = 16'h0050;
            s_upd_pred_taken  = 1'b0;
            s_upd_pred_target = 16'h0000;
            @(negedge clock);
            check_value("sat_lu_hit",     32'(sa_lu_hit),     32'(i > 0));
            check_value("sat_br_count",   32'(sa_br_count),   32'((i < 15) ? i : 15));
            check_value("sat_miss_count", 32'(sa_miss_count), 32'((i < 15) ? i : 15));
            check_value("m0_lu_hit",      32'(m0_lu_hit),     32'h0);
            check_value("m0_lu_taken",    32'(m0_lu_taken),   32'h0);
            check_value("m0_lu_next_pc",  32'(m0_lu_next_pc), 32'h0032);
            check_value("m0_mispredict",  32'(m0_mispredict), 32'h1);
            check_value("m0_redirect_pc", 32'(m0_redirect_pc), 32'h0050);
            $display("txn sat/mode0 #%0d sat_br=%0d sat_miss=%0d m0_taken=%b m0_mp=%b m0_redir=%h",
                     i, sa_br_count, sa_miss_count, m0_lu_taken, m0_mispredict, m0_redirect_pc);
            @(posedge clock);
            #1;
        end
        s_upd_valid = 1'b0;
        @(negedge clock);
        check_value("sat_br_final",    32'(sa_br_count),   32'd15);
        check_value("sat_miss_final",  32'(sa_miss_count), 32'd15);
        check_value("sat_lu_taken",    32'(sa_lu_taken),   32'h1);
        check_value("sat_lu_next_pc",  32'(sa_lu_next_pc), 32'h0050);
        check_value("m0_br_final",     32'(m0_br_count),   32'd20);
        check_value("m0_miss_final",   32'(m0_miss_count), 32'd20);
        check_value("m0_mispredict_idle", 32'(m0_mispredict), 32'h0);
        $display("txn final sat_br=%0d sat_miss=%0d m0_br=%0d m0_miss=%0d",
                 sa_br_count, sa_miss_count, m0_br_count, m0_miss_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised dynamic branch predictor for the 16-bit pipelined PMIPS core. It replaces the fixed resolve-in-MEM, flush-on-taken scheme with a direct-mapped branch target buffer and a table of saturating direction counters.
- The IF stage looks up the fetch PC combinationally and receives a predicted next PC.
- The EX stage returns the resolved outcome, which updates the table and raises mispredict/redirect.
- Performance counters are included for board debug.

Parameters:
PC_W, 16, PC/target width in bits
ENTRIES, 16, table depth; power of two, minimum 2; IDX_W = log2(ENTRIES)
CTR_W, 2, direction counter width, minimum 1
CNT_W, 16, width of each performance counter
MODE, 1, 0 = static not-taken (table frozen), 1 = bimodal

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
lu_pc  in  PC_W  IF fetch PC
lu_hit  out  1  valid entry with matching tag exists
lu_taken  out  1  predicted taken
lu_next_pc  out  PC_W  predicted next fetch PC
upd_valid  in  1  resolved branch present in EX this cycle
upd_pc  in  PC_W  PC of the resolved branch
upd_taken  in  1  actual direction
upd_target  in  PC_W  actual taken target
upd_pred_taken  in  1  prediction carried down the pipe with this branch
upd_pred_target  in  PC_W  predicted next PC carried with this branch
mispredict  out  1  flush IF/ID and ID/EX
redirect_pc  out  PC_W  correct next PC when mispredict=1
br_count  out  CNT_W  resolved branches
miss_count  out  CNT_W  mispredictions

Behaviour:
- Reset is synchronous and active-high; the clock and reset ports are named clock and reset.

Table addressing and entry format:
- PCs are halfword aligned; bit 0 is ignored.
- index = pc[IDX_W:1]; tag = pc[PC_W-1:IDX_W+1].
- Each entry holds: valid, tag, target[PC_W], ctr[CTR_W].

Lookup (combinational, zero latency):
- lu_hit = valid[idx] & (tag match).
- lu_taken = MODE & lu_hit & ctr[CTR_W-1].
- lu_next_pc = lu_taken ? target : lu_pc+2, computed modulo 2^PC_W (0xFFFE+2 = 0x0000).

Resolution (combinational on the upd_* inputs):
- mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & (upd_target != upd_pred_target))).
- redirect_pc = upd_taken ? upd_target : upd_pc+2.
- Both outputs are 0 whenever upd_valid=0.

Table update (at the rising edge, when upd_valid=1 and MODE=1):
- Hit: the counter saturating-increments if taken and saturating-decrements if not taken.
  - Saturation limits are 0 and 2^CTR_W-1.
  - If taken, target <= upd_target.
- Miss and taken: allocate the entry, overwriting any alias:
  - valid=1, tag written, target=upd_target, ctr=2^(CTR_W-1) (weak taken).
- Miss and not taken: no write.

MODE=0:
- The table is never written.
- lu_taken is always 0.
- Performance counters still run.

Performance counters:
- br_count increments on every upd_valid.
- miss_count increments on every mispredict.
- Both saturate at all-ones; neither wraps.

Same cycle, same index for lookup and update:
- Lookup returns the pre-update contents; there is no bypass.
- The new contents are visible in the next cycle.

Reset:
- All valid bits are cleared.
- All counters go to 2^(CTR_W-1)-1 (weak not-taken). Targets and tags are don't-care.
- br_count and miss_count are cleared.
- Reset has priority over an update in the same cycle, so an update mid-reset is discarded.

Output values immediately after reset:
- lu_hit=0, lu_taken=0, lu_next_pc=lu_pc+2.
- mispredict and redirect_pc follow the upd_* inputs (0 if upd_valid=0).

Decomposition:
- Shared package pmips_pkg holds: PC_STEP=2, the default PC_W, and the function clog2 used for IDX_W.
- One sub-module, sat_counter:
  - CTR_W-wide saturating up/down counter.
  - Inputs: inc/dec enable, direction, synchronous load with value.
  - Instantiated once per table entry via generate.
  - The same sub-module is reused for the performance counters (load unused).

Test Plan:
- Defaults after reset, lu_pc=0x0010 -> lu_hit=0, lu_taken=0, lu_next_pc=0x0012, br_count=0, miss_count=0.
- Allocation: upd_pc=0x0020, taken, target=0x0040, pred_taken=0 -> same cycle mispredict=1, redirect_pc=0x0040. Next cycle lu_pc=0x0020 -> lu_hit=1, lu_taken=1, lu_next_pc=0x0040; br_count=1, miss_count=1.
- Hysteresis: after allocation, 3 taken updates -> ctr=3, stays 3.
  - 1 not-taken update -> ctr=2, still lu_taken=1.
  - 2nd not-taken update -> ctr=1, lu_taken=0, lu_next_pc=0x0022.
- Aliasing: 0x0020 allocated, lookup 0x0040 (same index 0, different tag) -> lu_hit=0. Taken update at 0x0040 -> 0x0020 now misses and 0x0040 hits.
- Same-cycle conflict: lookup and first taken update of 0x0060 in the same cycle -> lu_hit=0 that cycle, lu_hit=1 next cycle.
  - With reset=1 asserted alongside an update -> entry not allocated, counters remain 0.
- Saturation and mode: CNT_W=4, 20 mispredicting updates -> miss_count=15, br_count=15.
  - MODE=0 with taken updates -> lu_taken stays 0, mispredict=1 per taken branch, redirect_pc=target.
